// File: rtl/snn_pkg.sv
// Shared constants and event types for the spiking-neuron readout path.
package snn_pkg;

  localparam int TS_W_DEF = 16;
  localparam int V_W_DEF  = 8;
  localparam int EV_W     = TS_W_DEF + V_W_DEF;

  // Reference membrane samples of the QIF neuron (reset level and spike peak).
  localparam logic signed [V_W_DEF-1:0] V_RESET = -8'sd20;
  localparam logic signed [V_W_DEF-1:0] VPEAK   = 8'sd50;

  typedef struct packed {
    logic [TS_W_DEF-1:0]        ts;
    logic signed [V_W_DEF-1:0]  v;
  } spike_event_t;

  function automatic int ev_width(input int ts_w, input int v_w);
    return ts_w + v_w;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop frees the head slot at the same edge.
module event_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by level.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Turns neuron spike edges into timestamped {ts, V} events, buffers them and
// streams them out on a valid/ready interface, counting any that are dropped.
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = 4,
  parameter int V_W   = V_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    spike_in,
  input  logic [V_W-1:0]          v_in,
  input  logic                    clr,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [TS_W-1:0]         ev_ts,
  output logic [V_W-1:0]          ev_v,
  output logic                    ts_wrap,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam int LOCAL_EV_W = TS_W + V_W;

  logic [TS_W-1:0]       ts;
  logic                  spike_d;
  logic                  fire;
  logic                  full;
  logic                  empty;
  logic                  drop;
  logic [LOCAL_EV_W-1:0] head;

  assign fire     = ena && spike_in && !spike_d;
  assign ev_valid = !empty;
  assign drop     = fire && full && !(ev_valid && ev_ready);
  assign ev_ts    = head[LOCAL_EV_W-1:V_W];
  assign ev_v     = head[V_W-1:0];

  // ts_wrap is registered so it is high exactly while ts reads 0 after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts      <= '0;
      ts_wrap <= 1'b0;
      spike_d <= 1'b0;
    end else begin
      spike_d <= spike_in;
      ts_wrap <= ena && (ts == '1);
      if (ena) ts <= ts + 1'b1;
    end
  end

  // A drop in the same cycle as clr survives the clear as a single count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  event_fifo #(
    .W     (LOCAL_EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .din   ({ts, v_in}),
    .pop   (ev_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed and randomized checks of spike_event_encoder against a queue-based
// model of the event stream (TS_W=4 so the timestamp wraps often).
module tb_spike_event_encoder;
  import snn_pkg::*;

  localparam int TS_W  = 4;
  localparam int DEPTH = 4;
  localparam int V_W   = 8;
  localparam int TS_MOD = 1 << TS_W;

  typedef struct {
    logic [TS_W-1:0] ts;
    logic [V_W-1:0]  v;
  } ev_rec_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ena = 1'b0;
  logic                    spike_in = 1'b0;
  logic [V_W-1:0]          v_in = '0;
  logic                    clr = 1'b0;
  logic                    ev_valid;
  logic                    ev_ready = 1'b0;
  logic [TS_W-1:0]         ev_ts;
  logic [V_W-1:0]          ev_v;
  logic                    ts_wrap;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic [7:0]              drop_cnt;

  int total = 0;
  int bad = 0;

  ev_rec_t q[$];
  int  m_ts;
  bit  m_sd;
  bit  m_wrap;
  bit  m_ovf;
  int  m_drops;

  spike_event_encoder #(.TS_W(TS_W), .DEPTH(DEPTH), .V_W(V_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spike_in (spike_in),
    .v_in     (v_in),
    .clr      (clr),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ts    (ev_ts),
    .ev_v     (ev_v),
    .ts_wrap  (ts_wrap),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    checkValue({step, ":ev_valid"}, 32'(ev_valid), 32'(q.size() > 0));
    checkValue({step, ":level"}, 32'(level), 32'(q.size()));
    checkValue({step, ":overflow"}, 32'(overflow), 32'(m_ovf));
    checkValue({step, ":drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
    checkValue({step, ":ts_wrap"}, 32'(ts_wrap), 32'(m_wrap));
    if (q.size() > 0) begin
      checkValue({step, ":ev_ts"}, 32'(ev_ts), 32'(q[0].ts));
      checkValue({step, ":ev_v"}, 32'(ev_v), 32'(q[0].v));
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_ts = 0;
    m_sd = 0;
    m_wrap = 0;
    m_ovf = 0;
    m_drops = 0;
  endtask

  // One clock: drive inputs, advance the model by the stream rules, check.
  task automatic applyStimulus(input string step, input bit sp, input logic [V_W-1:0] v,
                               input bit rdy, input bit en, input bit cl);
    bit fire, pop, dropped;
    ev_rec_t e;
    spike_in = sp;
    v_in     = v;
    ev_ready = rdy;
    ena      = en;
    clr      = cl;
    fire    = en && sp && !m_sd;
    pop     = rdy && (q.size() > 0);
    dropped = fire && (q.size() == DEPTH) && !pop;
    e.ts = TS_W'(m_ts);
    e.v  = v;
    if (pop) void'(q.pop_front());
    if (fire && !dropped) q.push_back(e);
    if (cl) begin
      m_ovf   = dropped;
      m_drops = dropped ? 1 : 0;
    end else if (dropped) begin
      m_ovf   = 1;
      m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    end
    m_wrap = en && (m_ts == TS_MOD - 1);
    if (en) m_ts = (m_ts + 1) % TS_MOD;
    m_sd = sp;
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  initial begin
    logic [V_W-1:0] rv;
    int wraps;
    modelReset();
    #1;
    checkOutput("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single pulse stamped at ts=5, then drained.
    repeat (5) applyStimulus("idle", 0, 0, 0, 1, 0);
    applyStimulus("pulse", 1, VPEAK, 0, 1, 0);
    applyStimulus("pulse_seen", 0, 0, 0, 1, 0);
    checkValue("pulse_ts5", 32'(ev_ts), 32'd5);
    applyStimulus("pulse_pop", 0, 0, 1, 1, 0);

    // Level held high for six cycles yields one event.
    for (int i = 0; i < 6; i++) applyStimulus("held", 1, V_RESET, 0, 1, 0);
    applyStimulus("held_low", 0, 0, 0, 1, 0);
    checkValue("held_one_event", 32'(level), 32'd1);
    applyStimulus("held_pop", 0, 0, 1, 1, 0);

    // Five spikes into a stalled FIFO: one drop.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("fill_hi", 1, 8'($urandom), 0, 1, 0);
      applyStimulus("fill_lo", 0, 0, 0, 1, 0);
    end
    checkValue("ovf_drop1", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 0, 0, 1, 1, 0);
    applyStimulus("clr", 0, 0, 0, 1, 1);

    // Full FIFO with simultaneous pop accepts the new event.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("full_hi", 1, 8'($urandom), 0, 1, 0);
      applyStimulus("full_lo", 0, 0, 0, 1, 0);
    end
    applyStimulus("full_swap", 1, 8'h5A, 1, 1, 0);
    checkValue("full_swap_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus("drain2", 0, 0, 1, 1, 0);

    // Timestamp wrap, spike on the wrapped cycle, and ena=0 freeze.
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus("wrap_run", 0, 0, 1, 1, 0);
      if (ts_wrap) wraps++;
    end
    while (m_ts != 0) applyStimulus("to_wrap", 0, 0, 1, 1, 0);
    applyStimulus("wrap_spike", 1, 8'h11, 0, 1, 0);
    checkValue("wrap_stamp0", 32'(ev_ts), 32'd0);
    applyStimulus("wrap_lo", 0, 0, 1, 1, 0);
    applyStimulus("freeze_spike", 1, 8'h22, 0, 0, 0);
    applyStimulus("freeze_lo", 0, 0, 0, 0, 0);
    applyStimulus("freeze_lo", 0, 0, 0, 0, 0);
    applyStimulus("thaw_spike", 1, 8'h33, 0, 1, 0);
    applyStimulus("thaw_pop", 0, 0, 1, 1, 0);

    // Asynchronous reset with three events buffered.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("pre_rst_hi", 1, 8'($urandom), 0, 1, 0);
      applyStimulus("pre_rst_lo", 0, 0, 0, 1, 0);
    end
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst_spike", 1, VPEAK, 0, 1, 0);
    checkValue("post_rst_ts0", 32'(ev_ts), 32'd0);

    // Randomized traffic including saturation pressure and clears.
    for (int i = 0; i < 400; i++) begin
      rv = 8'($urandom);
      applyStimulus("random", 1'($urandom_range(0, 1)), rv, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0));
    end

    $display("[TB] wrap pulses in 20-cycle run: %0d", wraps);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_encoder.md
# spike_event_encoder

Downstream consumer of the QIF neuron's `spike_out`/`V` outputs. Detects each spike, stamps it with a free-running cycle timestamp and the neuron's 8-bit V sample, buffers events in a small FIFO, and presents them on a valid/ready stream to the readout or serializer stage. Overflow is counted, never silently lost.

## Interface
Parameters:
- `TS_W`, 16: timestamp width.
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `V_W`, 8: V sample width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: enables timestamp counting and spike capture.
- `spike_in` in 1: neuron spike output.
- `v_in` in V_W: neuron V output, signed.
- `clr` in 1: synchronous clear of the drop counter and sticky overflow flag.
- `ev_valid` out 1: head event available.
- `ev_ready` in 1: consumer accepts head event.
- `ev_ts` out TS_W: head event timestamp.
- `ev_v` out V_W: head event V sample.
- `ts_wrap` out 1: one-cycle pulse when the timestamp wraps.
- `level` out clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky, set on any dropped event.
- `drop_cnt` out 8: saturating dropped-event count.

## Operation
- Timestamp `ts` counts +1 per cycle while `ena`=1 and holds while `ena`=0. It wraps from 2^TS_W−1 to 0. `ts_wrap` is 1 in the cycle after the wrap edge, i.e. while `ts`=0 following a wrap. It is not asserted after reset.
- Edge detect uses a registered `spike_d`. An event fires in a cycle where `ena`=1, `spike_in`=1 and `spike_d`=0. A level held high for several cycles is one event. `spike_d` updates every cycle regardless of `ena`.
- The event payload is {`ts`, `v_in`}, both sampled in the same cycle the edge is detected. `ts` is the pre-increment value.
- Push and pop:
  - If the FIFO is not full, the event is pushed.
  - If the FIFO is full and a pop occurs in the same cycle (`ev_valid`&&`ev_ready`), the push is accepted and `level` stays at DEPTH.
  - If the FIFO is full and there is no pop, the event is dropped: `overflow`←1 and `drop_cnt` increments, saturating at 255.
- `clr`=1 zeroes `drop_cnt` and `overflow`. If a drop coincides with `clr`, the result is `overflow`=1 and `drop_cnt`=1.
- Output is first-word-fall-through: `ev_ts`/`ev_v` show the head entry whenever `ev_valid`=1. Values are don't-care when `ev_valid`=0.
- Handshake rules:
  - A transfer happens on a cycle with `ev_valid`&&`ev_ready`.
  - Once `ev_valid` is asserted it stays asserted, with stable payload, until the transfer.
  - `ev_ready` may toggle freely and is not required to wait for valid.
- Reset values: `ts`=0, FIFO empty, `ev_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `ts_wrap`=0, `spike_d`=0.
- Reset mid-operation discards all buffered events immediately (async). Outputs take their reset values.

## Timing
- Spike edge sampled at edge N → entry written at N. `ev_valid`=1 after edge N if the FIFO was empty: one-cycle latency, registered.
- Pop at edge M → the next entry is visible after edge M. Back-to-back transfers each cycle are supported.
- `level` reflects push/pop at the same edge. A simultaneous push and pop leaves `level` unchanged.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `ev_ready` to `ev_valid`.
- `ev_ts`/`ev_v` are driven by an array read at the registered read pointer. This is acceptable at DEPTH≤8.

## Structure
- Shared package `snn_pkg`:
  - constants `TS_W_DEF`=16, `V_W_DEF`=8;
  - the event struct/width `EV_W`=TS_W+V_W;
  - V_RESET=−20 and VPEAK=50, used by the bench for expected samples.
- Sub-module `event_fifo`: generic FWFT FIFO with parameters (W, DEPTH), ports push/pop/full/empty/level, and the full-and-pop accept rule.
- `spike_event_encoder` holds the timestamp counter, edge detector, drop logic and the `event_fifo` instance.

## Test plan
- Reset, then `ena`=1 and a single `spike_in` pulse at `ts`=5 with `v_in`=50 → `ev_valid` next cycle; `ev_ts`=5, `ev_v`=50; `level`=1. With `ev_ready`=1 → `level`=0 and `ev_valid`=0 after one edge.
- `spike_in` held high 6 cycles → exactly one event, and `ev_ts` equals the first high cycle's `ts`.
- `ev_ready`=0 and 5 spikes at DEPTH=4 → `level`=4, `overflow`=1, `drop_cnt`=1. Drain → timestamps of spikes 1–4 in order. Then `clr` → `drop_cnt`=0, `overflow`=0.
- FIFO full and a spike coinciding with `ev_ready`=1 → no drop, `level` stays 4, and the new entry appears last.
- TS_W=4, run 20 cycles with `ena`=1 → `ts_wrap` pulses exactly once, when `ts`=0 after 15. A spike at the wrapped cycle is stamped 0. With `ena`=0 the spike is ignored and `ts` is frozen.
- Assert `rst_n`=0 mid-stream with `level`=3 → immediately `ev_valid`=0, `level`=0, `drop_cnt`=0. After release the first spike is stamped from `ts`=0.
